// File: rtl/bip_control.sv
// Instruction sequencer for the accumulator processor: owns PC and IR and runs
// a FETCH/EXEC loop, issuing one-cycle datapath strobes for each instruction.
module bip_control #(
    parameter int addr_bus    = 11,
    parameter int data_size   = 16,
    parameter int count_width = 32
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    output logic [addr_bus-1:0]    Prog_Addr,
    input  logic [data_size-1:0]   Prog_Data,
    output logic [addr_bus-1:0]    Data_Addr,
    output logic                   Data_WrEn,
    output logic [data_size-1:0]   Operand,
    output logic [1:0]             SelA,
    output logic                   SelB,
    output logic                   Alu_Op,
    output logic                   WrAcc,
    output logic                   Busy,
    output logic                   Halted,
    output logic                   Bad_Op,
    output logic [count_width-1:0] Cycle_Count
);

    localparam int OPW = 5;

    localparam logic [OPW-1:0] OP_HLT  = 5'b00000;
    localparam logic [OPW-1:0] OP_STO  = 5'b00001;
    localparam logic [OPW-1:0] OP_LD   = 5'b00010;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00011;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00100;
    localparam logic [OPW-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00110;
    localparam logic [OPW-1:0] OP_SUBI = 5'b00111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [addr_bus-1:0]    r_pc;
    logic [data_size-1:0]   r_ir;
    logic [count_width-1:0] r_cnt;
    logic                   r_bad;
    logic                   r_wren;
    logic                   r_wracc;
    logic [1:0]             r_sela;
    logic                   r_selb;
    logic                   r_aluop;
    logic                   r_busy;
    logic                   r_halted;

    logic [OPW-1:0]         w_fetch_opc;
    logic [OPW-1:0]         w_ir_opc;
    logic                   w_ir_undef;
    logic                   w_ir_stop;
    logic [5:0]             w_fetch_ctrl;

    // Control word packing: {Data_WrEn, WrAcc, SelA[1:0], SelB, Alu_Op}
    function automatic logic [5:0] f_decode(input logic [OPW-1:0] opc);
        logic [5:0] ctrl;
        ctrl = 6'b0;
        case (opc)
            OP_STO:  ctrl = 6'b1_0_00_0_0;
            OP_LD:   ctrl = 6'b0_1_00_0_0;
            OP_LDI:  ctrl = 6'b0_1_01_0_0;
            OP_ADD:  ctrl = 6'b0_1_10_0_0;
            OP_ADDI: ctrl = 6'b0_1_10_1_0;
            OP_SUB:  ctrl = 6'b0_1_10_0_1;
            OP_SUBI: ctrl = 6'b0_1_10_1_1;
            default: ctrl = 6'b0;
        endcase
        return ctrl;
    endfunction

    assign w_fetch_opc  = Prog_Data[data_size-1 -: OPW];
    assign w_ir_opc     = r_ir[data_size-1 -: OPW];
    assign w_ir_undef   = (w_ir_opc > OP_SUBI);
    assign w_ir_stop    = (w_ir_opc == OP_HLT) || w_ir_undef;
    // Strobes are registered at the end of FETCH so they appear for exactly the EXEC cycle.
    assign w_fetch_ctrl = f_decode(w_fetch_opc);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_ir     <= '0;
            r_cnt    <= '0;
            r_bad    <= 1'b0;
            r_wren   <= 1'b0;
            r_wracc  <= 1'b0;
            r_sela   <= 2'b00;
            r_selb   <= 1'b0;
            r_aluop  <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_wren  <= 1'b0;
            r_wracc <= 1'b0;
            r_sela  <= 2'b00;
            r_selb  <= 1'b0;
            r_aluop <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_ir    <= Prog_Data;
                    r_pc    <= r_pc + addr_bus'(1);
                    r_cnt   <= r_cnt + count_width'(1);
                    r_state <= S_EXEC;
                    r_busy  <= 1'b1;
                    {r_wren, r_wracc, r_sela, r_selb, r_aluop} <= w_fetch_ctrl;
                end
                S_EXEC: begin
                    r_cnt <= r_cnt + count_width'(1);
                    if (w_ir_stop) begin
                        r_state  <= S_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                        if (w_ir_undef) r_bad <= 1'b1;
                    end else begin
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                    end
                end
                S_HALT: begin
                    r_state  <= S_HALT;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Prog_Addr   = r_pc;
    assign Data_Addr   = r_ir[addr_bus-1:0];
    assign Operand     = {{(data_size-addr_bus){r_ir[addr_bus-1]}}, r_ir[addr_bus-1:0]};
    assign Data_WrEn   = r_wren;
    assign WrAcc       = r_wracc;
    assign SelA        = r_sela;
    assign SelB        = r_selb;
    assign Alu_Op      = r_aluop;
    assign Busy        = r_busy;
    assign Halted      = r_halted;
    assign Bad_Op      = r_bad;
    assign Cycle_Count = r_cnt;

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control: program memory is a TB array read combinationally.
module tb_bip_control;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [10:0] Prog_Addr;
    logic [15:0] Prog_Data;
    logic [10:0] Data_Addr;
    logic        Data_WrEn;
    logic [15:0] Operand;
    logic [1:0]  SelA;
    logic        SelB;
    logic        Alu_Op;
    logic        WrAcc;
    logic        Busy;
    logic        Halted;
    logic        Bad_Op;
    logic [31:0] Cycle_Count;

    logic [15:0] prog_mem [0:2047];
    int          n_chk;
    int          n_err;

    bip_control #(.addr_bus(11), .data_size(16), .count_width(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .Prog_Addr(Prog_Addr), .Prog_Data(Prog_Data),
        .Data_Addr(Data_Addr), .Data_WrEn(Data_WrEn), .Operand(Operand),
        .SelA(SelA), .SelB(SelB), .Alu_Op(Alu_Op), .WrAcc(WrAcc),
        .Busy(Busy), .Halted(Halted), .Bad_Op(Bad_Op), .Cycle_Count(Cycle_Count)
    );

    assign Prog_Data = prog_mem[Prog_Addr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] arg);
        return {op, arg};
    endfunction

    function automatic logic [5:0] ctrl();
        return {Data_WrEn, WrAcc, SelA, SelB, Alu_Op};
    endfunction

    task automatic clear_mem();
        for (int a = 0; a < 2048; a++) prog_mem[a] = 16'h0000;
    endtask

    task automatic do_reset();
        Start = 1'b0;
        Reset = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    // Returns at the negedge inside the first FETCH cycle.
    task automatic start_pulse();
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic load_default();
        clear_mem();
        prog_mem[0] = ins(5'd3, 11'd16);
        prog_mem[1] = ins(5'd1, 11'd1);
        prog_mem[2] = ins(5'd2, 11'd1);
        prog_mem[3] = ins(5'd5, 11'd255);
        prog_mem[4] = ins(5'd1, 11'd2);
        prog_mem[5] = ins(5'd2, 11'd16);
        prog_mem[6] = ins(5'd0, 11'd0);
    endtask

    // Expected EXEC control words {WrEn, WrAcc, SelA, SelB, AluOp} and operands.
    logic [5:0]  exp_ctrl [0:6];
    logic [10:0] exp_arg  [0:6];

    initial begin
        n_chk = 0;
        n_err = 0;
        exp_ctrl[0] = 6'b0_1_01_0_0; exp_arg[0] = 11'd16;
        exp_ctrl[1] = 6'b1_0_00_0_0; exp_arg[1] = 11'd1;
        exp_ctrl[2] = 6'b0_1_00_0_0; exp_arg[2] = 11'd1;
        exp_ctrl[3] = 6'b0_1_10_1_0; exp_arg[3] = 11'd255;
        exp_ctrl[4] = 6'b1_0_00_0_0; exp_arg[4] = 11'd2;
        exp_ctrl[5] = 6'b0_1_00_0_0; exp_arg[5] = 11'd16;
        exp_ctrl[6] = 6'b0_0_00_0_0; exp_arg[6] = 11'd0;

        // Asynchronous reset in the middle of an STO EXEC
        load_default();
        do_reset();
        start_pulse();
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        check("sto_wren_before_rst", Data_WrEn, 1'b1);
        #2 Reset = 1'b0;
        #1;
        check("rst_wren",   Data_WrEn, 1'b0);
        check("rst_ctrl",   ctrl(), 6'b0);
        check("rst_pc",     Prog_Addr, 11'd0);
        check("rst_busy",   Busy, 1'b0);
        check("rst_halted", Halted, 1'b0);
        check("rst_bad",    Bad_Op, 1'b0);
        check("rst_cnt",    Cycle_Count, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;

        // Default program
        do_reset();
        start_pulse();
        for (int i = 0; i < 7; i++) begin
            check($sformatf("fetch_pc_%0d", i), Prog_Addr, 11'(i));
            check($sformatf("fetch_ctrl_%0d", i), ctrl(), 6'b0);
            check($sformatf("fetch_busy_%0d", i), Busy, 1'b1);
            @(negedge Clk);
            check($sformatf("exec_ctrl_%0d", i), ctrl(), exp_ctrl[i]);
            check($sformatf("exec_daddr_%0d", i), Data_Addr, exp_arg[i]);
            if (i == 3) check("addi_operand", Operand, 16'd255);
            @(negedge Clk);
        end
        check("dflt_halted", Halted, 1'b1);
        check("dflt_busy",   Busy, 1'b0);
        check("dflt_cnt",    Cycle_Count, 32'd14);
        check("dflt_pc",     Prog_Addr, 11'd7);
        check("dflt_ctrl",   ctrl(), 6'b0);

        // Sign extension on SUBI 0x7FF
        clear_mem();
        prog_mem[0] = ins(5'd7, 11'h7FF);
        do_reset();
        start_pulse();
        @(negedge Clk);
        check("subi_operand", Operand, 16'hFFFF);
        check("subi_ctrl",    ctrl(), 6'b0_1_10_1_1);
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        check("subi_halted",  Halted, 1'b1);
        check("subi_cnt",     Cycle_Count, 32'd4);

        // Undefined opcode halts and sets the sticky flag
        clear_mem();
        prog_mem[0] = ins(5'b01010, 11'd5);
        prog_mem[1] = ins(5'd1, 11'd3);
        do_reset();
        start_pulse();
        @(negedge Clk);
        check("bad_exec_ctrl", ctrl(), 6'b0);
        @(negedge Clk);
        check("bad_halted", Halted, 1'b1);
        check("bad_flag",   Bad_Op, 1'b1);
        check("bad_cnt",    Cycle_Count, 32'd2);
        start_pulse();
        repeat (4) begin
            check("bad_start_ctrl", ctrl(), 6'b0);
            @(negedge Clk);
        end
        check("bad_still_halted", Halted, 1'b1);
        check("bad_busy",         Busy, 1'b0);
        check("bad_cnt_hold",     Cycle_Count, 32'd2);
        check("bad_pc_hold",      Prog_Addr, 11'd1);

        // PC wrap: 2047 ADDs then HLT at 2047, Start held high throughout
        for (int a = 0; a < 2047; a++) prog_mem[a] = ins(5'd4, 11'd0);
        prog_mem[2047] = ins(5'd0, 11'd0);
        do_reset();
        @(negedge Clk);
        Start = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            if (Halted) break;
            @(negedge Clk);
        end
        check("wrap_halted", Halted, 1'b1);
        check("wrap_pc",     Prog_Addr, 11'd0);
        check("wrap_cnt",    Cycle_Count, 32'd4096);
        check("wrap_bad",    Bad_Op, 1'b0);
        Start = 1'b0;

        // Idle with Start low
        do_reset();
        repeat (20) @(negedge Clk);
        check("idle_busy",   Busy, 1'b0);
        check("idle_cnt",    Cycle_Count, 32'd0);
        check("idle_pc",     Prog_Addr, 11'd0);
        check("idle_halted", Halted, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
